weapon_fire_scheduler: RTL and testbench
========================================

Name: weapon_fire_scheduler

Overview:
- Arbitrates fire requests from several turrets onto one shared ammo magazine. The magazine is an internal saturating ammo counter.
- Sequences each shot as: grant, decrement by the fire rate, then a cooldown.
- Sequences a timed reload that adds rounds and saturates at a loadable maximum.
- Sits between the mode selector/turret controls and the weapons datapath. Shots are legal only in attack mode (mode_selector == 4'b0010).

Parameters:
- N_REQ, 4, number of requesting turrets.
- AMMO_W, 9, width of ammo, rate, reload and max values.
- COOL_W, 4, width of the cooldown count.
- RELOAD_CYCLES, 8, cycles spent in RELOAD before rounds are added (>=1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- mode_selector  input  4  ship mode; 4'b0010 = attack.
- fire_req  input  N_REQ  level fire request, one bit per turret.
- fire_rate  input  AMMO_W  rounds consumed per shot.
- cooldown  input  COOL_W  cycles of lockout after a shot.
- reload_req  input  1  start a reload.
- reload_amount  input  AMMO_W  rounds added per reload.
- max_load  input  1  load ammo_max_in into the max register.
- ammo_max_in  input  AMMO_W  new magazine capacity.
- fire_grant  output  N_REQ  one-hot, one-cycle pulse for the granted turret.
- ammo  output  AMMO_W  current round count.
- reloading  output  1  high while in RELOAD.
- busy  output  1  high in COOLDOWN or RELOAD.
- error  output  1  one-cycle pulse on an illegal request.
- error_code  output  2  00 none, 01 wrong mode, 10 insufficient ammo, 11 fire during reload.

Behaviour:
- One clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - ammo = 0, max = all ones, state = IDLE.
  - fire_grant = 0, error = 0, error_code = 00.
  - RR pointer = N_REQ-1, so turret 0 has highest priority first.
- rst asserted mid-operation abandons any cooldown or reload; no rounds are added.
- max register: on max_load it takes ammo_max_in at the next edge. If the new max is below ammo, ammo clamps to max one cycle later.
- FSM states: IDLE, COOLDOWN, RELOAD.
- IDLE, evaluated in priority order each cycle:
  1. reload_req -> RELOAD, reload counter = RELOAD_CYCLES. A concurrent fire_req is ignored without error.
  2. Otherwise, if any fire_req is set:
     - mode_selector != 4'b0010 -> error with code 01.
     - else fire_rate == 0 or ammo < fire_rate -> error with code 10.
     - else grant. Round-robin searches from pointer+1 upward with wrap. At the next edge: fire_grant[i] = 1, ammo -= fire_rate, pointer = i, cooldown counter = cooldown.
     - After a grant: cooldown == 0 -> stay in IDLE (back-to-back grants are possible); else -> COOLDOWN.
- COOLDOWN:
  - The counter decrements each cycle; the state exits to IDLE after exactly `cooldown` cycles.
  - fire_req is silently ignored.
  - reload_req is ignored.
- RELOAD:
  - The counter decrements each cycle. On the final cycle: ammo = min(ammo + reload_amount, max), computed at AMMO_W+1 bits with no wrap. Then -> IDLE.
  - Any fire_req -> error with code 11, no grant.
- Errors: error and error_code pulse for one cycle per offending cycle. If multiple conditions hold, precedence is 11 > 01 > 10.
- Latency:
  - Request sampled in IDLE -> grant and ammo update visible one cycle later.
  - Minimum spacing between grants is cooldown+1 cycles.
- ammo never underflows and never exceeds max.

Optional Feature:
- Macro: WEAPON_AUTO_RELOAD_EN.
- Defined: when a grant leaves ammo == 0, the FSM enters RELOAD directly after the shot instead of COOLDOWN or IDLE. The cooldown is skipped, and the reload uses the current reload_amount.
- Not defined: the empty magazine stays at 0 until reload_req is asserted; further fire_req produce error code 10.

Test Plan:
- Reset, max_load with 9'd100, reload_amount = 60, reload_req -> reloading for 8 cycles, ammo = 60. A second reload -> ammo = 100 (saturated).
- ammo = 60, attack mode, fire_rate = 5, cooldown = 2, fire_req = 4'b1111 held -> grants in order 0001, 0010, 0100, 1000, one every 3 cycles; ammo 55, 50, 45, 40.
- mode_selector = 4'b0001 with fire_req = 4'b0001 -> error = 1, code 01, ammo unchanged. Reload in progress with fire_req -> code 11.
- ammo = 3, fire_rate = 5 -> code 10, no grant. fire_rate = 3 -> grant, ammo = 0.
- rst asserted on cycle 4 of RELOAD -> ammo = 0, state IDLE, no rounds added. max_load with 9'd20 while ammo = 40 -> ammo = 20 two cycles later.
- WEAPON_AUTO_RELOAD_EN defined, ammo = 5, fire_rate = 5 -> grant, then reloading = 1 on the next cycle; ammo = reload_amount after 8 cycles.

Source files
------------

// File: rtl/weapon_fire_scheduler.sv
// Shared-magazine fire scheduler: round-robin turret grants, cooldown lockout, timed saturating reload.
// Latency: a request sampled in IDLE shows its grant and ammo update one cycle later; reload completes after RELOAD_CYCLES.
// Backpressure: requests are level-held; they are ignored in COOLDOWN and flagged as errors in RELOAD. Optional: WEAPON_AUTO_RELOAD_EN.
module weapon_fire_scheduler #(
  parameter int N_REQ         = 4,
  parameter int AMMO_W        = 9,
  parameter int COOL_W        = 4,
  parameter int RELOAD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode_selector,
  input  logic [N_REQ-1:0]  fire_req,
  input  logic [AMMO_W-1:0] fire_rate,
  input  logic [COOL_W-1:0] cooldown,
  input  logic              reload_req,
  input  logic [AMMO_W-1:0] reload_amount,
  input  logic              max_load,
  input  logic [AMMO_W-1:0] ammo_max_in,
  output logic [N_REQ-1:0]  fire_grant,
  output logic [AMMO_W-1:0] ammo,
  output logic              reloading,
  output logic              busy,
  output logic              error,
  output logic [1:0]        error_code
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RLD_W = $clog2(RELOAD_CYCLES + 1);
  localparam int CNT_W = (COOL_W > RLD_W) ? COOL_W : RLD_W;

  // Encoding chosen so that reloading is a direct state bit.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_COOL   = 2'b01;
  localparam logic [1:0] ST_RELOAD = 2'b10;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_MODE   = 2'b01;
  localparam logic [1:0] ERR_AMMO   = 2'b10;
  localparam logic [1:0] ERR_RELOAD = 2'b11;

  localparam logic [3:0] MODE_ATTACK = 4'b0010;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [AMMO_W-1:0] max_q;

  logic              any_req;
  logic              shot_ok;
  logic [AMMO_W-1:0] ammo_after;
  logic [AMMO_W-1:0] ammo_after_sat;
  logic [AMMO_W:0]   reload_sum;
  logic [AMMO_W-1:0] reload_sat;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;

  assign any_req        = |fire_req;
  assign shot_ok        = (fire_rate != '0) && (ammo >= fire_rate);
  assign ammo_after     = ammo - fire_rate;
  assign ammo_after_sat = (ammo_after > max_q) ? max_q : ammo_after;
  // One extra bit so the add can never wrap before saturation.
  assign reload_sum     = {1'b0, ammo} + {1'b0, reload_amount};
  assign reload_sat     = (reload_sum > {1'b0, max_q}) ? max_q : reload_sum[AMMO_W-1:0];

  assign reloading = state[1];
  assign busy      = |state;

  // Round-robin pick: first requesting turret after the last one granted, with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    cand     = rr_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (!pick_vld && fire_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Scheduler FSM, magazine counter, capacity register and pulsed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rr_ptr     <= IDX_W'(N_REQ - 1);
      max_q      <= '1;
      ammo       <= '0;
      fire_grant <= '0;
      error      <= 1'b0;
      error_code <= ERR_NONE;
    end else begin
      fire_grant <= '0;
      error      <= 1'b0;
      error_code <= ERR_NONE;

      if (max_load) begin
        max_q <= ammo_max_in;
      end
      // A shrunken capacity pulls the count down one cycle after the load.
      if (ammo > max_q) begin
        ammo <= max_q;
      end

      case (state)
        ST_IDLE: begin
          if (reload_req) begin
            state <= ST_RELOAD;
            cnt   <= CNT_W'(RELOAD_CYCLES);
          end else if (any_req) begin
            if (mode_selector != MODE_ATTACK) begin
              error      <= 1'b1;
              error_code <= ERR_MODE;
            end else if (!shot_ok) begin
              error      <= 1'b1;
              error_code <= ERR_AMMO;
            end else if (pick_vld) begin
              fire_grant <= N_REQ'(1) << pick_idx;
              ammo       <= ammo_after_sat;
              rr_ptr     <= pick_idx;
              cnt        <= CNT_W'(cooldown);
`ifdef WEAPON_AUTO_RELOAD_EN
              if (ammo_after == '0) begin
                state <= ST_RELOAD;
                cnt   <= CNT_W'(RELOAD_CYCLES);
              end else if (cooldown != '0) begin
                state <= ST_COOL;
              end
`else
              if (cooldown != '0) begin
                state <= ST_COOL;
              end
`endif
            end
          end
        end
        ST_COOL: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state <= ST_IDLE;
          end
        end
        ST_RELOAD: begin
          if (any_req) begin
            error      <= 1'b1;
            error_code <= ERR_RELOAD;
          end
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) begin
            ammo  <= reload_sat;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weapon_fire_scheduler.sv
// Bench for weapon_fire_scheduler: cycle vector table plus reload-length and grant-spacing sequences.
// Expected values come from the table and the sequences; they pass through a scoreboard queue.
// Covers both builds of WEAPON_AUTO_RELOAD_EN.
module tb_weapon_fire_scheduler;

  localparam int ATK = 2;
  localparam int NRM = 1;
`ifdef WEAPON_AUTO_RELOAD_EN
  localparam int AUTO = 1;
`else
  localparam int AUTO = 0;
`endif
  localparam int A0 = AUTO ? 20 : 0;
  localparam int A1 = AUTO ? 20 : 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode_selector;
  logic [3:0] fire_req;
  logic [8:0] fire_rate;
  logic [3:0] cooldown;
  logic       reload_req;
  logic [8:0] reload_amount;
  logic       max_load;
  logic [8:0] ammo_max_in;
  logic [3:0] fire_grant;
  logic [8:0] ammo;
  logic       reloading;
  logic       busy;
  logic       error;
  logic [1:0] error_code;

  weapon_fire_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .mode_selector (mode_selector),
    .fire_req      (fire_req),
    .fire_rate     (fire_rate),
    .cooldown      (cooldown),
    .reload_req    (reload_req),
    .reload_amount (reload_amount),
    .max_load      (max_load),
    .ammo_max_in   (ammo_max_in),
    .fire_grant    (fire_grant),
    .ammo          (ammo),
    .reloading     (reloading),
    .busy          (busy),
    .error         (error),
    .error_code    (error_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [8:0] a;
    logic       rl;
    logic       b;
    logic       e;
    logic [1:0] c;
  } obs_t;

  typedef struct {
    logic       r;
    logic [3:0] m;
    logic [3:0] req;
    logic [8:0] rate;
    logic [3:0] cd;
    logic       rlr;
    logic [8:0] amt;
    logic       mld;
    logic [8:0] mxin;
    int         n;
    obs_t       exp;
  } vec_t;

  vec_t tbl[$];
  obs_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input int r, input int m, input int req, input int rate,
                              input int cd, input int rlr, input int amt, input int mld,
                              input int mxin, input int n, input int g, input int a,
                              input int rl, input int b, input int e, input int c);
    vec_t v;
    v.r = 1'(r);  v.m = 4'(m);  v.req = 4'(req);  v.rate = 9'(rate);
    v.cd = 4'(cd);  v.rlr = 1'(rlr);  v.amt = 9'(amt);  v.mld = 1'(mld);
    v.mxin = 9'(mxin);  v.n = n;
    v.exp.g = 4'(g);  v.exp.a = 9'(a);  v.exp.rl = 1'(rl);
    v.exp.b = 1'(b);  v.exp.e = 1'(e);  v.exp.c = 2'(c);
    return v;
  endfunction

  function automatic obs_t cur();
    obs_t o;
    o.g = fire_grant;  o.a = ammo;  o.rl = reloading;
    o.b = busy;  o.e = error;  o.c = error_code;
    return o;
  endfunction

  task automatic chk_obs(input string nm, input obs_t got, input obs_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got grant=%b ammo=%0d rl=%b busy=%b err=%b code=%b, want grant=%b ammo=%0d rl=%b busy=%b err=%b code=%b",
                  nm, got.g, got.a, got.rl, got.b, got.e, got.c,
                  want.g, want.a, want.rl, want.b, want.e, want.c);
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  task automatic apply(input vec_t v);
    rst = v.r;  mode_selector = v.m;  fire_req = v.req;  fire_rate = v.rate;
    cooldown = v.cd;  reload_req = v.rlr;  reload_amount = v.amt;
    max_load = v.mld;  ammo_max_in = v.mxin;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e;
    int   k;

    // Vector table: {rst, mode, req, rate, cd, reload_req, amount, max_load, max_in, cycles} -> {grant, ammo, rl, busy, err, code}.
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 60, 1, 100, 1, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 1, 60, 0, 0,   1, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 60, 0, 0,   7, 0,   0, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 60, 0, 0,   1, 0,  60, 0, 0, 0, 0));
    for (int t = 0; t < 4; t++) begin
      tbl.push_back(mk(0, ATK, 15, 5, 2, 0, 60, 0, 0, 1, 1 << t, 55 - 5 * t, 0, 1, 0, 0));
      tbl.push_back(mk(0, ATK, 15, 5, 2, 1, 60, 0, 0, 1, 0,      55 - 5 * t, 0, 1, 0, 0));
      tbl.push_back(mk(0, ATK, 15, 5, 2, 0, 60, 0, 0, 1, 0,      55 - 5 * t, 0, 0, 0, 0));
    end
    tbl.push_back(mk(0, NRM, 1,  5,   2, 0, 60, 0, 0,  1, 0,  40, 0, 0, 1, 1));
    tbl.push_back(mk(0, NRM, 0,  5,   2, 0, 60, 0, 0,  1, 0,  40, 0, 0, 0, 0));
    tbl.push_back(mk(0, NRM, 4,  100, 2, 0, 60, 0, 0,  1, 0,  40, 0, 0, 1, 1));
    tbl.push_back(mk(0, ATK, 15, 5,   2, 1, 60, 0, 0,  1, 0,  40, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 1,  5,   2, 0, 60, 0, 0,  1, 0,  40, 1, 1, 1, 3));
    tbl.push_back(mk(0, NRM, 1,  5,   2, 0, 60, 0, 0,  1, 0,  40, 1, 1, 1, 3));
    tbl.push_back(mk(0, ATK, 0,  5,   2, 0, 60, 0, 0,  5, 0,  40, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 0,  5,   2, 0, 60, 0, 0,  1, 0, 100, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 0,  5,   2, 0, 60, 1, 20, 1, 0, 100, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 0,  5,   2, 0, 60, 0, 0,  1, 0,  20, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 1,  17,  0, 0, 60, 0, 0,  1, 1,   3, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 2,  5,   0, 0, 60, 0, 0,  1, 0,   3, 0, 0, 1, 2));
    tbl.push_back(mk(0, ATK, 2,  0,   0, 0, 60, 0, 0,  1, 0,   3, 0, 0, 1, 2));
    tbl.push_back(mk(0, ATK, 11, 3,   0, 0, 60, 0, 0,  1, 2,   0, AUTO, AUTO, 0, 0));
    if (AUTO != 0) begin
      tbl.push_back(mk(0, ATK, 0, 3, 0, 0, 60, 0, 0, 7, 0,  0, 1, 1, 0, 0));
      tbl.push_back(mk(0, ATK, 0, 3, 0, 0, 60, 0, 0, 1, 0, 20, 0, 0, 0, 0));
    end else begin
      tbl.push_back(mk(0, ATK, 4, 3, 0, 0, 60, 0, 0, 1, 0,  0, 0, 0, 1, 2));
    end
    tbl.push_back(mk(0, ATK, 0, 5, 2, 1, 10, 0, 0, 1,  0, A0, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 10, 0, 0, 7,  0, A0, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 10, 0, 0, 1,  0, A1, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 1, 10, 0, 0, 1,  0, A1, 1, 1, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 10, 0, 0, 2,  0, A1, 1, 1, 0, 0));
    tbl.push_back(mk(1, ATK, 0, 5, 2, 0, 10, 0, 0, 1,  0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, ATK, 0, 5, 2, 0, 10, 0, 0, 12, 0,  0, 0, 0, 0, 0));

    // Reset state.
    rst = 1'b1;  mode_selector = 4'b0010;  fire_req = '0;  fire_rate = 9'd5;
    cooldown = 4'd2;  reload_req = 1'b0;  reload_amount = 9'd60;
    max_load = 1'b0;  ammo_max_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_obs("reset", cur(), '0);

    // Table, one scoreboard entry per cycle.
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        apply(tbl[i]);
        sb.push_back(tbl[i].exp);
        @(posedge clk);
        #1;
        chk_obs($sformatf("row%0d.cyc%0d", i, c), cur(), sb.pop_front());
      end
    end

    // Reload length and capacity restored to all ones by reset: 0 + 300 fits.
    rst = 1'b0;  fire_req = '0;  max_load = 1'b0;
    reload_amount = 9'd300;  reload_req = 1'b1;
    e = '0;  e.a = 9'd300;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reload_req = 1'b0;
    k = 0;
    while (reloading && k < 20) begin
      k++;
      @(posedge clk);
      #1;
    end
    chk_int("reload_cycles", k, 8);
    chk_obs("reload_300", cur(), sb.pop_front());

    // Pointer reset favours turret 0; next grant after cooldown+1 cycles goes to turret 1.
    mode_selector = 4'b0010;  fire_req = 4'b1111;  fire_rate = 9'd5;  cooldown = 4'd3;
    e = '0;  e.g = 4'b0001;  e.a = 9'd295;  e.b = 1'b1;
    sb.push_back(e);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (fire_grant == '0 && k < 10);
    chk_obs("first_grant", cur(), sb.pop_front());
    chk_int("grant_latency", k, 1);

    e = '0;  e.g = 4'b0010;  e.a = 9'd290;  e.b = 1'b1;
    sb.push_back(e);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (fire_grant == '0 && k < 10);
    chk_obs("second_grant", cur(), sb.pop_front());
    chk_int("grant_spacing", k, 4);
    fire_req = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
